// File: rtl/ex_div_if.sv
// Handshake bundle between the execute stage / hazard logic and the iterative divider.
interface ex_div_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            ex_advance;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            stall_req;

    modport master (
        output flush, start, op, a, b, ex_advance,
        input  busy, done, result, stall_req
    );

    modport slave (
        input  flush, start, op, a, b, ex_advance,
        output busy, done, result, stall_req
    );
endinterface

// File: rtl/ex_div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), one restoring step per cycle, with a
// one-cycle path for divide-by-zero and signed overflow.
module ex_div_unit #(
    parameter int XLEN = 32
) (
    input  logic   clk,
    input  logic   reset,
    ex_div_if.slave div
);
    localparam int CW = $clog2(XLEN);

    // state  | meaning
    // S_IDLE | waiting for start; operands sampled here
    // S_CALC | restoring steps, counter counts XLEN-1 down to 0
    // S_DONE | result valid, held until the EX stage advances
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] dvd, dvs, rem, res;
    logic            is_rem, q_neg, r_neg;
    logic            ld_fast, ld_calc, fin;

    logic            op_signed, a_neg, b_neg, div_zero, ovf;
    logic [XLEN-1:0] a_abs, b_abs, fast_res, rem_step, dvd_step, final_res;
    logic [XLEN:0]   shifted, diff;
    logic            qbit;

    function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] x);
        return ~x + 1'b1;
    endfunction

    always_comb begin
        op_signed = ~div.op[0];
        a_neg     = op_signed & div.a[XLEN-1];
        b_neg     = op_signed & div.b[XLEN-1];
        a_abs     = a_neg ? neg(div.a) : div.a;
        b_abs     = b_neg ? neg(div.b) : div.b;
        div_zero  = (div.b == '0);
        ovf       = op_signed && (div.a == {1'b1, {(XLEN-1){1'b0}}}) && (&div.b);
        if (div_zero)
            fast_res = div.op[1] ? div.a : '1;
        else
            fast_res = div.op[1] ? '0 : div.a;
    end

    // The shifted partial remainder is compared with one extra bit so a divisor
    // with its msb set never loses the carry out of the shift.
    always_comb begin
        shifted   = {rem, dvd[XLEN-1]};
        diff      = shifted - {1'b0, dvs};
        qbit      = ~diff[XLEN];
        rem_step  = qbit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        dvd_step  = {dvd[XLEN-2:0], qbit};
        if (is_rem)
            final_res = r_neg ? neg(rem_step) : rem_step;
        else
            final_res = q_neg ? neg(dvd_step) : dvd_step;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ld_fast   = 1'b0;
        ld_calc   = 1'b0;
        fin       = 1'b0;
        if (div.flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (div.start) begin
                        if (div_zero || ovf) begin
                            ld_fast   = 1'b1;
                            state_nxt = S_DONE;
                        end else begin
                            ld_calc   = 1'b1;
                            state_nxt = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (cnt == '0) begin
                        fin       = 1'b1;
                        state_nxt = S_DONE;
                    end
                end
                S_DONE: begin
                    if (div.ex_advance) state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            dvd    <= '0;
            dvs    <= '0;
            rem    <= '0;
            res    <= '0;
            is_rem <= 1'b0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
        end else begin
            if (ld_fast) res <= fast_res;
            if (ld_calc) begin
                dvd    <= a_abs;
                dvs    <= b_abs;
                rem    <= '0;
                cnt    <= CW'(XLEN - 1);
                is_rem <= div.op[1];
                q_neg  <= a_neg ^ b_neg;
                r_neg  <= a_neg;
            end
            if (state == S_CALC && !div.flush) begin
                dvd <= dvd_step;
                rem <= rem_step;
                if (cnt != '0) cnt <= cnt - 1'b1;
            end
            if (fin) res <= final_res;
        end
    end

    assign div.busy      = (state == S_CALC);
    assign div.done      = (state == S_DONE);
    assign div.result    = res;
    assign div.stall_req = ~reset & (((state == S_IDLE) & div.start) | (state == S_CALC));
endmodule
